// File: rtl/video_pkg.sv
// Shared video timing constants, helpers and types for the scanout path.
package video_pkg;

  // Default 640x480@60 timing.
  localparam int unsigned HA_DEFAULT  = 640;
  localparam int unsigned HFP_DEFAULT = 16;
  localparam int unsigned HS_DEFAULT  = 96;
  localparam int unsigned HBP_DEFAULT = 48;
  localparam int unsigned VA_DEFAULT  = 480;
  localparam int unsigned VFP_DEFAULT = 10;
  localparam int unsigned VS_DEFAULT  = 2;
  localparam int unsigned VBP_DEFAULT = 33;

  // Sync levels carried as the actual line levels, not as asserted flags.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port, video output and renderer handshake of the scanout block.
interface framebuffer_scanout_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              ce;
  logic              render_done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_buf;
  logic              rd_data;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic              pixel;
  logic              swap;

  modport master (
    input  ce, render_done, rd_data,
    output rd_en, rd_addr, rd_buf, hsync, vsync, de, pixel, swap
  );

  modport slave (
    output ce, render_done, rd_data,
    input  rd_en, rd_addr, rd_buf, hsync, vsync, de, pixel, swap
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster h/v counters with combinational active and sync decode of the current position.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned HOR_ACTIVE_PIXELS = HA_DEFAULT,
  parameter int unsigned HOR_FRONT_PORCH   = HFP_DEFAULT,
  parameter int unsigned HOR_SYNC          = HS_DEFAULT,
  parameter int unsigned HOR_BACK_PORCH    = HBP_DEFAULT,
  parameter int unsigned VER_ACTIVE_PIXELS = VA_DEFAULT,
  parameter int unsigned VER_FRONT_PORCH   = VFP_DEFAULT,
  parameter int unsigned VER_SYNC          = VS_DEFAULT,
  parameter int unsigned VER_BACK_PORCH    = VBP_DEFAULT,
  parameter bit          HSYNC_ACTIVE      = 1'b0,
  parameter bit          VSYNC_ACTIVE      = 1'b0,
  parameter int unsigned H_CNT_W = $clog2(h_total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH,
                                                  HOR_SYNC, HOR_BACK_PORCH)),
  parameter int unsigned V_CNT_W = $clog2(v_total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH,
                                                  VER_SYNC, VER_BACK_PORCH))
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  output logic [H_CNT_W-1:0] h_cnt_o,
  output logic [V_CNT_W-1:0] v_cnt_o,
  output logic               active_o,
  output logic               hsync_o,
  output logic               vsync_o
);

  localparam int unsigned HT = h_total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH, HOR_SYNC,
                                       HOR_BACK_PORCH);
  localparam int unsigned VT = v_total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH, VER_SYNC,
                                       VER_BACK_PORCH);

  localparam logic [H_CNT_W-1:0] HLast   = H_CNT_W'(HT - 1);
  localparam logic [V_CNT_W-1:0] VLast   = V_CNT_W'(VT - 1);
  localparam logic [H_CNT_W-1:0] HActEnd = H_CNT_W'(HOR_ACTIVE_PIXELS);
  localparam logic [V_CNT_W-1:0] VActEnd = V_CNT_W'(VER_ACTIVE_PIXELS);
  localparam logic [H_CNT_W-1:0] HsBeg   = H_CNT_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
  localparam logic [H_CNT_W-1:0] HsEnd   = H_CNT_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH
                                                    + HOR_SYNC);
  localparam logic [V_CNT_W-1:0] VsBeg   = V_CNT_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
  localparam logic [V_CNT_W-1:0] VsEnd   = V_CNT_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH
                                                    + VER_SYNC);

  logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;

  // Next raster position: h wraps at end of line and steps v, v wraps at end of frame.
  always_comb begin
    h_cnt_d = h_cnt_q + H_CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + V_CNT_W'(1);
    end
  end

  // Counter state, advancing only on pixel-rate enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (ce_i) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Decode of the current position into active area and sync line levels.
  always_comb begin
    h_cnt_o  = h_cnt_q;
    v_cnt_o  = v_cnt_q;
    active_o = (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
    hsync_o  = ((h_cnt_q >= HsBeg) && (h_cnt_q < HsEnd)) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    vsync_o  = ((v_cnt_q >= VsBeg) && (v_cnt_q < VsEnd)) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
  end

endmodule

// File: rtl/framebuffer_scanout.sv
// Front-buffer reader: raster timing, read pipeline, output alignment and buffer swap.
module framebuffer_scanout
  import video_pkg::*;
#(
  parameter int unsigned HOR_ACTIVE_PIXELS = HA_DEFAULT,
  parameter int unsigned HOR_FRONT_PORCH   = HFP_DEFAULT,
  parameter int unsigned HOR_SYNC          = HS_DEFAULT,
  parameter int unsigned HOR_BACK_PORCH    = HBP_DEFAULT,
  parameter int unsigned VER_ACTIVE_PIXELS = VA_DEFAULT,
  parameter int unsigned VER_FRONT_PORCH   = VFP_DEFAULT,
  parameter int unsigned VER_SYNC          = VS_DEFAULT,
  parameter int unsigned VER_BACK_PORCH    = VBP_DEFAULT,
  parameter bit          HSYNC_ACTIVE      = 1'b0,
  parameter bit          VSYNC_ACTIVE      = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  framebuffer_scanout_if.master bus
);

  localparam int unsigned HT = h_total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH, HOR_SYNC,
                                       HOR_BACK_PORCH);
  localparam int unsigned VT = v_total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH, VER_SYNC,
                                       VER_BACK_PORCH);
  localparam int unsigned HW     = $clog2(HT);
  localparam int unsigned VW     = $clog2(VT);
  localparam int unsigned ADDR_W = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

  localparam sync_t SyncRst = '{hsync: ~HSYNC_ACTIVE, vsync: ~VSYNC_ACTIVE, de: 1'b0};

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              active, hs_raw, vs_raw;
  logic              frame_end, swap_point;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  sync_t             s0_q, s0_d, s1_q;
  logic              swap_q, swap_d;
  logic              rd_buf_q, rd_buf_d;

  video_timing_gen #(
    .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
    .HOR_FRONT_PORCH   (HOR_FRONT_PORCH),
    .HOR_SYNC          (HOR_SYNC),
    .HOR_BACK_PORCH    (HOR_BACK_PORCH),
    .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
    .VER_FRONT_PORCH   (VER_FRONT_PORCH),
    .VER_SYNC          (VER_SYNC),
    .VER_BACK_PORCH    (VER_BACK_PORCH),
    .HSYNC_ACTIVE      (HSYNC_ACTIVE),
    .VSYNC_ACTIVE      (VSYNC_ACTIVE),
    .H_CNT_W           (HW),
    .V_CNT_W           (VW)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .ce_i     (bus.ce),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .active_o (active),
    .hsync_o  (hs_raw),
    .vsync_o  (vs_raw)
  );

  assign frame_end  = (h_cnt == HW'(HT - 1)) && (v_cnt == VW'(VT - 1));
  // First pixel of vertical blank: no reads pending, safe point to flip buffers.
  assign swap_point = (h_cnt == '0) && (v_cnt == VW'(VER_ACTIVE_PIXELS));

  // Next-state for the linear address counter, swap pulse, buffer select and stage 0 syncs.
  always_comb begin
    addr_d = addr_q;
    if (frame_end) begin
      addr_d = '0;
    end else if (active) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    swap_d   = swap_point & bus.render_done;
    rd_buf_d = rd_buf_q ^ swap_d;
    s0_d     = '{hsync: hs_raw, vsync: vs_raw, de: active};
  end

  // Stage 0 (read issue) and stage 1 (align with rd_data); everything holds while ce=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      s0_q      <= SyncRst;
      s1_q      <= SyncRst;
      swap_q    <= 1'b0;
      rd_buf_q  <= 1'b0;
    end else if (bus.ce) begin
      addr_q    <= addr_d;
      rd_en_q   <= active;
      rd_addr_q <= addr_q;
      s0_q      <= s0_d;
      s1_q      <= s0_q;
      swap_q    <= swap_d;
      rd_buf_q  <= rd_buf_d;
    end
  end

  // Output drive; pixel is gated so it is 0 outside the visible area.
  always_comb begin
    bus.rd_en   = rd_en_q;
    bus.rd_addr = rd_addr_q;
    bus.rd_buf  = rd_buf_q;
    bus.hsync   = s1_q.hsync;
    bus.vsync   = s1_q.vsync;
    bus.de      = s1_q.de;
    bus.pixel   = s1_q.de & bus.rd_data;
    bus.swap    = swap_q;
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on a 16x8 raster with an 8x4 visible area.
module tb_framebuffer_scanout;

  localparam int unsigned HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int unsigned VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = 16, VT = 8, FT = HT * VT;
  localparam int SwapPos = VA * HT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  framebuffer_scanout_if #(.ADDR_W(5)) bus ();

  framebuffer_scanout #(
    .HOR_ACTIVE_PIXELS (HA),
    .HOR_FRONT_PORCH   (HFP),
    .HOR_SYNC          (HS),
    .HOR_BACK_PORCH    (HBP),
    .VER_ACTIVE_PIXELS (VA),
    .VER_FRONT_PORCH   (VFP),
    .VER_SYNC          (VS),
    .VER_BACK_PORCH    (VBP),
    .HSYNC_ACTIVE      (1'b0),
    .VSYNC_ACTIVE      (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: one-ce read latency, stored bit is addr[0].
  always_ff @(posedge clk) begin
    if (rst) bus.rd_data <= 1'b0;
    else if (bus.ce && bus.rd_en) bus.rd_data <= bus.rd_addr[0];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cur_k   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (k=%0d): got %0h expected %0h", tag, cur_k, got, exp);
    end
  endtask

  function automatic bit act(input int p);
    int x, y;
    x = p % HT;
    y = (p / HT) % VT;
    return (x < int'(HA)) && (y < int'(VA));
  endfunction

  // k = number of ce edges since reset release; stage 0 shows position k-1, stage 1 k-2.
  task automatic check_outputs(input int k, input bit swap_e, input bit buf_e);
    int p, x, y;
    cur_k = k;
    if (k == 0) begin
      check("rd_en", 32'(bus.rd_en), 0);
      check("rd_addr", 32'(bus.rd_addr), 0);
    end else begin
      p = k - 1;
      x = p % HT;
      y = (p / HT) % VT;
      check("rd_en", 32'(bus.rd_en), 32'(act(p)));
      if (act(p)) check("rd_addr", 32'(bus.rd_addr), y * int'(HA) + x);
    end
    if (k < 2) begin
      check("de", 32'(bus.de), 0);
      check("hsync", 32'(bus.hsync), 1);
      check("vsync", 32'(bus.vsync), 1);
      check("pixel", 32'(bus.pixel), 0);
    end else begin
      p = k - 2;
      x = p % HT;
      y = (p / HT) % VT;
      check("de", 32'(bus.de), 32'(act(p)));
      check("hsync", 32'(bus.hsync), (x >= 10 && x < 13) ? 0 : 1);
      check("vsync", 32'(bus.vsync), (y >= 5 && y < 7) ? 0 : 1);
      check("pixel", 32'(bus.pixel), act(p) ? (x % 2) : 0);
    end
    check("rd_buf", 32'(bus.rd_buf), 32'(buf_e));
    check("swap", 32'(bus.swap), 32'(swap_e));
  endtask

  initial begin
    bit buf_m;
    int rd_cnt, swaps, k;

    rst = 1'b1;
    bus.ce = 1'b1;
    bus.render_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs(0, 1'b0, 1'b0);
    rst = 1'b0;

    // Three frames at full rate: swap in frame 0, none in frame 1, swap again in frame 2.
    buf_m  = 1'b0;
    rd_cnt = 0;
    swaps  = 0;
    for (int n = 1; n <= 3 * FT + 16; n++) begin
      bit rdn, sw;
      rdn = ((n - 1) / FT) != 1;
      bus.render_done = rdn;
      @(posedge clk);
      @(negedge clk);
      sw = (((n - 1) % FT) == SwapPos) && rdn;
      if (sw) buf_m = ~buf_m;
      check_outputs(n, sw, buf_m);
      if (n <= FT && bus.rd_en) rd_cnt++;
      if (bus.swap) swaps++;
    end
    check("rd_en_count_frame0", 32'(rd_cnt), 32);
    check("swap_count", 32'(swaps), 2);

    // ce at 1-of-3, reset issued mid-line at (5,2), then restart from (0,0).
    bus.render_done = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int c = 0; c < 200 && k < 37; c++) begin
      bus.ce = (c % 3) == 0;
      @(posedge clk);
      if (bus.ce) k++;
      @(negedge clk);
      check_outputs(k, 1'b0, 1'b0);
    end
    check("ce_edges_before_reset", 32'(k), 37);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.ce = (c % 3) == 0;
      @(posedge clk);
      @(negedge clk);
    end
    check_outputs(0, 1'b0, 1'b0);
    rst = 1'b0;
    k = 0;
    for (int c = 0; c < 36; c++) begin
      bus.ce = (c % 3) == 0;
      @(posedge clk);
      if (bus.ce) k++;
      @(negedge clk);
      check_outputs(k, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
